keypad_event_decoder: RTL and testbench

//   Consumer side of the 4x4 matrix-scanner output (flag + 5-bit code). Turns the

---
 rtl/keypad_event_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_keypad_event_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_decoder
// Description : Turns the 4x4 matrix scanner's intermittent per-line hits
//               into one debounced, release-gated press event per keystroke,
//               buffered in a small FIFO behind a valid/ready port.
// Ports       : clk_in        system clock (same clock as the scanner divider)
//               rst_n         asynchronous reset, active low
//               scan_flag     scanner flag, asynchronous to clk_in
//               scan_code     scanner code 0..15 (16..31 ignored)
//               key_valid     FIFO head holds an event
//               key_code      FIFO head code, meaningful while key_valid=1
//               key_ready     consumer accepts head when key_valid&key_ready
//               fifo_full     FIFO holds FIFO_DEPTH entries
//               overflow      sticky: a press was dropped on a full FIFO
//               overflow_clr  synchronous clear of overflow
// Revision    : 1.0  initial release
// ============================================================================
module keypad_event_decoder #(
  parameter int PRESS_HITS     = 3,     // 1..15
  parameter int RELEASE_CYCLES = 8192,  // must exceed 4 scan periods
  parameter int FIFO_DEPTH     = 4      // power of 2, >= 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       scan_flag,
  input  logic [4:0] scan_code,
  output logic       key_valid,
  output logic [4:0] key_code,
  input  logic       key_ready,
  output logic       fifo_full,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_QUIET_W = $clog2(RELEASE_CYCLES + 1);

  localparam logic [c_QUIET_W-1:0] c_QUIET_MAX   = c_QUIET_W'(RELEASE_CYCLES);
  localparam logic [3:0]           c_PRESS_HITS  = 4'(PRESS_HITS);
  localparam logic [c_CNT_W-1:0]   c_DEPTH       = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input capture: 2-FF synchronizers plus one extra flag stage for edge detect
  // --------------------------------------------------------------------------
  logic       r_flag_s1, r_flag_s2, r_flag_d;
  logic [4:0] r_code_s1, r_code_s2;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_s1 <= 1'b0;
      r_flag_s2 <= 1'b0;
      r_flag_d  <= 1'b0;
      r_code_s1 <= 5'd0;
      r_code_s2 <= 5'd0;
    end else begin
      r_flag_s1 <= scan_flag;
      r_flag_s2 <= r_flag_s1;
      r_flag_d  <= r_flag_s2;
      r_code_s1 <= scan_code;
      r_code_s2 <= r_code_s1;
    end
  end

  // Codes 16..31 have bit 4 set and never count as hits.
  logic w_hit;
  assign w_hit = r_flag_s2 & ~r_flag_d & ~r_code_s2[4];

  // --------------------------------------------------------------------------
  // Press FSM
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [4:0]            r_cand;
  logic [3:0]            r_hitcnt;
  logic [c_QUIET_W-1:0]  r_quiet;
  logic                  w_quiet_done;
  logic                  w_push;

  assign w_quiet_done = (r_quiet == c_QUIET_MAX);

  // Push coincides with the transition into HELD.
  always_comb begin
    w_push = 1'b0;
    case (r_state)
      ST_IDLE: w_push = w_hit && (c_PRESS_HITS == 4'd1);
      ST_ARM:  w_push = w_hit && (r_code_s2 == r_cand) &&
                        ((r_hitcnt + 4'd1) == c_PRESS_HITS);
      default: w_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cand   <= 5'd0;
      r_hitcnt <= 4'd0;
      r_quiet  <= '0;
    end else begin
      // Quiet counter: cleared by any hit, saturates at the release threshold.
      if (w_hit) begin
        r_quiet <= '0;
      end else if (!w_quiet_done) begin
        r_quiet <= r_quiet + c_QUIET_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_cand   <= r_code_s2;
            r_hitcnt <= 4'd1;
            r_state  <= w_push ? ST_HELD : ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_hit) begin
            if (r_code_s2 == r_cand) begin
              r_hitcnt <= r_hitcnt + 4'd1;
              if (w_push) begin
                r_state <= ST_HELD;
              end
            end else begin
              // A different key took over before acceptance: start over on it.
              r_cand   <= r_code_s2;
              r_hitcnt <= 4'd1;
            end
          end else if (w_quiet_done) begin
            r_state <= ST_IDLE;
          end
        end
        ST_HELD: begin
          // Any hit keeps the key held; other codes never roll over.
          if (!w_hit && w_quiet_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  logic [4:0]           r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_key_valid;
  logic [4:0]           r_key_code;
  logic                 r_overflow;

  logic                 w_pop, w_full, w_wr_en, w_drop;
  logic [c_CNT_W-1:0]   w_count_left;
  logic [c_PTR_W-1:0]   w_rd_ptr_nxt;

  assign w_pop        = r_key_valid & key_ready;
  assign w_full       = (r_count == c_DEPTH);
  // A pop in the same cycle frees the slot the push needs.
  assign w_wr_en      = w_push & (~w_full | w_pop);
  assign w_drop       = w_push & w_full & ~w_pop;
  // Entries that remain after this cycle's pop, excluding this cycle's push:
  // a freshly pushed event therefore surfaces one cycle after its push.
  assign w_count_left = r_count - c_CNT_W'(w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);

  always_ff @(posedge clk_in) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_cand_or_code();
    end
  end

  // The pushed code is the candidate, or the hit code when accepted from IDLE.
  function automatic logic [4:0] r_cand_or_code();
    return (r_state == ST_IDLE) ? r_code_s2 : r_cand;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= 5'd0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_left + c_CNT_W'(w_wr_en);

      // Head register; holds its code while the consumer stalls.
      r_key_valid <= (w_count_left != '0);
      if (w_count_left != '0) begin
        r_key_code <= r_mem[w_rd_ptr_nxt];
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_event_decoder
// Description : Self-checking bench for keypad_event_decoder. A keystroke-level
//               reference model (one event per stroke of >= PRESS_HITS hits,
//               FIFO as a queue) predicts the events the consumer must see.
// Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_event_decoder;

  localparam int PH = 3;
  localparam int RC = 200;
  localparam int FD = 4;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       scan_flag;
  logic [4:0] scan_code;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic       fifo_full;
  logic       overflow;
  logic       overflow_clr;

  always #5 clk_in = ~clk_in;

  keypad_event_decoder #(
    .PRESS_HITS    (PH),
    .RELEASE_CYCLES(RC),
    .FIFO_DEPTH    (FD)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .scan_flag   (scan_flag),
    .scan_code   (scan_code),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [4:0] exp_q[$];
  bit         model_ovf;

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drive_hit(input logic [4:0] code);
    scan_code = code;
    scan_flag = 1'b1;
    tick(3);
    scan_flag = 1'b0;
  endtask

  // One keystroke: nhits hits of one code with sub-release gaps, then release.
  task automatic stroke(input logic [4:0] code, input int nhits, input bit noise);
    for (int i = 0; i < nhits; i++) begin
      drive_hit(code);
      tick($urandom_range(20, 60));
      if (noise && $urandom_range(0, 3) == 0) begin
        drive_hit(5'(16 + $urandom_range(0, 15)));
        tick($urandom_range(20, 60));
      end
    end
    tick(RC + 20);
  endtask

  // Reference model: a stroke yields an event iff it has enough hits;
  // the FIFO is a bounded queue that flags overflow when it would exceed FD.
  task automatic model_press(input logic [4:0] code, input int nhits);
    if (nhits >= PH) begin
      if (exp_q.size() < FD) exp_q.push_back(code);
      else model_ovf = 1'b1;
    end
  endtask

  // Wait (bounded) for an event and accept it; reports what was seen.
  task automatic pop_one(output logic v, output logic [4:0] c);
    int t = 0;
    while (key_valid !== 1'b1 && t < 30) begin
      tick(1);
      t++;
    end
    v = key_valid;
    c = key_code;
    if (v === 1'b1) begin
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; scan_flag = 1'b0; scan_code = 5'd0;
    key_ready = 1'b0; overflow_clr = 1'b0;
    tick(4);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", key_valid); else n_pass++;
    n_checks++; if (key_code !== 5'd0) $display("FAIL reset_key_code: got %0d want 0", key_code); else n_pass++;
    n_checks++; if (fifo_full !== 1'b0) $display("FAIL reset_fifo_full: got %b want 0", fifo_full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_single_press();
    logic v; logic [4:0] c;
    drive_hit(5'd9); tick(40);
    drive_hit(5'd9); tick(40);
    // Third hit: 2 sync stages + edge detect -> push, then head register.
    scan_code = 5'd9; scan_flag = 1'b1;
    tick(3);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", key_valid); else n_pass++;
    tick(1);
    scan_flag = 1'b0;
    n_checks++; if (key_valid !== 1'b1 || key_code !== 5'd9)
      $display("FAIL single_valid_latency: got valid=%b code=%0d want valid=1 code=9", key_valid, key_code); else n_pass++;
    tick(RC + 20);
    n_checks++; if (key_valid !== 1'b1 || key_code !== 5'd9)
      $display("FAIL single_hold_stable: got valid=%b code=%0d want valid=1 code=9", key_valid, key_code); else n_pass++;
    pop_one(v, c);
    tick(3);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL single_only_one: got valid=%b want 0", key_valid); else n_pass++;
  endtask

  task automatic test_bounce();
    stroke(5'd5, 2, 1'b0);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL bounce_no_event: got valid=%b want 0", key_valid); else n_pass++;
    // Had the 2-hit candidate survived the quiet period, this would complete it.
    stroke(5'd5, 2, 1'b0);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL bounce_back_to_idle: got valid=%b want 0", key_valid); else n_pass++;
  endtask

  task automatic test_hold();
    logic v; logic [4:0] c; logic [4:0] e;
    for (int i = 0; i < 20; i++) begin
      drive_hit(5'd3);
      tick($urandom_range(20, 60));
      if (i == 8)  begin drive_hit(5'd12); tick(30); end
      if (i == 12) begin drive_hit(5'd20); tick(30); end
    end
    tick(RC + 20);
    model_press(5'd3, 20);
    stroke(5'd3, 3, 1'b0);
    model_press(5'd3, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, c);
      n_checks++; if (v !== 1'b1 || c !== e)
        $display("FAIL hold_event: got valid=%b code=%0d want valid=1 code=%0d", v, c, e); else n_pass++;
    end
    tick(3);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL hold_extra_event: got valid=%b want 0", key_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    logic v; logic [4:0] c; logic [4:0] e;
    model_ovf = 1'b0;
    for (int k = 0; k < 5; k++) begin
      stroke(5'(k), 3, 1'b0);
      model_press(5'(k), 3);
      n_checks++; if (fifo_full !== (exp_q.size() == FD))
        $display("FAIL ovf_full_%0d: got %b want %b", k, fifo_full, exp_q.size() == FD); else n_pass++;
      n_checks++; if (overflow !== model_ovf)
        $display("FAIL ovf_flag_%0d: got %b want %b", k, overflow, model_ovf); else n_pass++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, c);
      n_checks++; if (v !== 1'b1 || c !== e)
        $display("FAIL ovf_drain: got valid=%b code=%0d want valid=1 code=%0d", v, c, e); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
    model_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic v; logic [4:0] c; logic [4:0] e; logic [4:0] newc;
    for (int k = 0; k < FD; k++) begin
      e = 5'($urandom_range(0, 15));
      stroke(e, 3, 1'b0);
      model_press(e, 3);
    end
    newc = 5'($urandom_range(0, 15));
    drive_hit(newc); tick(40);
    drive_hit(newc); tick(40);
    scan_code = newc; scan_flag = 1'b1;
    tick(2);
    e = exp_q.pop_front();
    n_checks++; if (key_valid !== 1'b1 || key_code !== e)
      $display("FAIL pp_head: got valid=%b code=%0d want valid=1 code=%0d", key_valid, key_code, e); else n_pass++;
    key_ready = 1'b1;           // pop lands on the same edge as the push
    tick(1);
    key_ready = 1'b0;
    model_press(newc, 3);
    tick(2);
    scan_flag = 1'b0;
    n_checks++; if (fifo_full !== 1'b1) $display("FAIL pp_full: got %b want 1", fifo_full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL pp_overflow: got %b want 0", overflow); else n_pass++;
    tick(RC + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, c);
      n_checks++; if (v !== 1'b1 || c !== e)
        $display("FAIL pp_order: got valid=%b code=%0d want valid=1 code=%0d", v, c, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_arm();
    logic v; logic [4:0] c;
    for (int k = 0; k < FD + 1; k++) begin
      stroke(5'($urandom_range(0, 15)), 3, 1'b0);
    end
    n_checks++; if (overflow !== 1'b1 || fifo_full !== 1'b1)
      $display("FAIL rst_precond: got overflow=%b full=%b want 1 1", overflow, fifo_full); else n_pass++;
    drive_hit(5'd7); tick(40);
    drive_hit(5'd7); tick(10);
    rst_n = 1'b0;
    #1;
    n_checks++; if (key_valid !== 1'b0 || key_code !== 5'd0 || fifo_full !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rst_async: got valid=%b code=%0d full=%b ovf=%b want all 0",
               key_valid, key_code, fifo_full, overflow); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    tick(3);
    drive_hit(5'd7); tick(40);
    drive_hit(5'd7); tick(40);
    n_checks++; if (key_valid !== 1'b0) $display("FAIL rst_candidate_kept: got valid=%b want 0", key_valid); else n_pass++;
    drive_hit(5'd7);
    tick(RC + 20);
    pop_one(v, c);
    n_checks++; if (v !== 1'b1 || c !== 5'd7)
      $display("FAIL rst_reaccept: got valid=%b code=%0d want valid=1 code=7", v, c); else n_pass++;
  endtask

  task automatic test_random();
    logic v; logic [4:0] c; logic [4:0] e; logic [4:0] code;
    int n; int nh;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, FD);
      for (int s = 0; s < n; s++) begin
        code = 5'($urandom_range(0, 15));
        nh   = $urandom_range(1, 5);
        stroke(code, nh, 1'b1);
        model_press(code, nh);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pop_one(v, c);
        n_checks++; if (v !== 1'b1 || c !== e)
          $display("FAIL rand_event_b%0d: got valid=%b code=%0d want valid=1 code=%0d", b, v, c, e); else n_pass++;
      end
      tick(3);
      n_checks++; if (key_valid !== 1'b0 || overflow !== 1'b0)
        $display("FAIL rand_empty_b%0d: got valid=%b ovf=%b want 0 0", b, key_valid, overflow); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_ovf = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_arm();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
